// File: rtl/phase_bank_ctrl_if.sv
// phase_bank_ctrl_if: UART-side byte handshake bundle (rx stream in, reply stream out)
interface phase_bank_ctrl_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  modport master (output rx_data, rx_valid, tx_ready, input rx_ready, tx_data, tx_valid);
  modport slave  (input rx_data, rx_valid, tx_ready, output rx_ready, tx_data, tx_valid);
endinterface

// File: rtl/phase_bank_ctrl.sv
// phase_bank_ctrl: framed command decoder + shadow/active phase bank; define PHASE_BANK_READBACK_EN for opcode-4 readback
module phase_bank_ctrl #(
  parameter int CHANNELS     = 88,
  parameter int OFFSET_WIDTH = 11,
  parameter int DUTY_WIDTH   = 10,
  parameter int ADDR_WIDTH   = 11
) (
  input  logic                             clk,
  input  logic                             rst,
  phase_bank_ctrl_if.slave                 bus,
  input  logic                             sync_in,
  output logic                             reload,
  output logic [CHANNELS*OFFSET_WIDTH-1:0] offsets,
  output logic [CHANNELS-1:0]              enables,
  output logic [CHANNELS*DUTY_WIDTH-1:0]   duties,
  output logic [7:0]                       frame_errs
);
  localparam int AI = CHANNELS > 1 ? $clog2(CHANNELS) : 1;
  localparam int W = OFFSET_WIDTH > DUTY_WIDTH ? OFFSET_WIDTH : DUTY_WIDTH;
  localparam logic [13:0] CH = 14'(CHANNELS);
  localparam logic [DUTY_WIDTH-1:0] DUTY_RST = DUTY_WIDTH'(1) << (DUTY_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, B1, B2, B3, EXEC, REPLY0, REPLY1} state_t;
  state_t state, nxt;
  logic [2:0] op;
  logic [ADDR_WIDTH-1:0] addr;
  logic [W-1:0] data;
  logic den, pending, sync_d, acc, hdr, err, addr_ok, swap, rd, two, nak;
  logic [7:0] rep1, rb0, rb1;
  logic [AI-1:0] idx;
  logic [OFFSET_WIDTH-1:0] sh_off [CHANNELS];
  logic [OFFSET_WIDTH-1:0] act_off [CHANNELS];
  logic [DUTY_WIDTH-1:0] sh_dut [CHANNELS];
  logic [DUTY_WIDTH-1:0] act_dut [CHANNELS];
  logic sh_en [CHANNELS];
  logic act_en [CHANNELS];
  assign acc = bus.rx_valid && bus.rx_ready;
  assign hdr = bus.rx_data[7];
  assign err = acc && (state == IDLE ? !hdr : hdr);
  assign addr_ok = 32'(addr) < CHANNELS;
  assign idx = addr[AI-1:0];
  assign swap = sync_in && !sync_d && pending;
`ifdef PHASE_BANK_READBACK_EN
  logic [12:0] ro;
  assign ro = 13'(act_off[idx]);
  assign rd = op == 3'd4 && addr_ok;
  assign rb0 = rd ? {1'b0, act_en[idx], ro[12:7]} : {1'b0, CH[13:7]};
  assign rb1 = rd ? {1'b0, ro[6:0]} : {1'b0, CH[6:0]};
`else
  assign rd = 1'b0;
  assign rb0 = {1'b0, CH[13:7]};
  assign rb1 = {1'b0, CH[6:0]};
`endif
  assign two = op == 3'd3 || rd;
  assign nak = op[2:1] == 2'b11 || (op == 3'd4 && !rd) || (op[2:1] == 2'b00 && !addr_ok);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:    nxt = acc && hdr ? B1 : IDLE;
      B1:      nxt = !acc ? B1 : hdr ? B1 : B2;
      B2:      nxt = !acc ? B2 : hdr ? B1 : B3;
      B3:      nxt = !acc ? B3 : hdr ? B1 : EXEC;
      EXEC:    nxt = two ? REPLY0 : nak ? REPLY1 : IDLE;
      REPLY0:  nxt = bus.tx_ready ? REPLY1 : REPLY0;
      REPLY1:  nxt = bus.tx_ready ? IDLE : REPLY1;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      bus.rx_ready <= 1'b0;
      bus.tx_valid <= 1'b0;
      bus.tx_data <= 8'd0;
      reload <= 1'b0;
      frame_errs <= 8'd0;
      sync_d <= 1'b0;
      pending <= 1'b1;
      op <= 3'd0;
      addr <= '0;
      data <= '0;
      den <= 1'b0;
      rep1 <= 8'd0;
    end else begin
      state <= nxt;
      bus.rx_ready <= nxt inside {IDLE, B1, B2, B3};
      sync_d <= sync_in;
      reload <= swap;
      // a commit landing on the swap edge stays pending for the next edge
      pending <= (state == EXEC && op == 3'd2) || (pending && !swap);
      if (err && frame_errs != 8'hff) frame_errs <= frame_errs + 8'd1;
      if (acc && hdr) {op, addr[3:0]} <= bus.rx_data[6:0];
      if (acc && !hdr && state == B1) addr[10:4] <= bus.rx_data[6:0];
      if (acc && !hdr && state == B2) begin
        den <= bus.rx_data[6];
        data <= W'({bus.rx_data[6:0], 7'd0});
      end
      if (acc && !hdr && state == B3) data <= data | W'(bus.rx_data[6:0]);
      if (state == EXEC && (two || nak)) begin
        bus.tx_valid <= 1'b1;
        bus.tx_data <= nak ? 8'h80 : rb0;
        rep1 <= rb1;
      end
      if (state == REPLY0 && bus.tx_ready) bus.tx_data <= rep1;
      if (state == REPLY1 && bus.tx_ready) bus.tx_valid <= 1'b0;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int c = 0; c < CHANNELS; c++) begin
        sh_off[c] <= '0;
        act_off[c] <= '0;
        sh_en[c] <= 1'b0;
        act_en[c] <= 1'b0;
        sh_dut[c] <= DUTY_RST;
        act_dut[c] <= DUTY_RST;
      end
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        if (swap) begin
          act_off[c] <= sh_off[c];
          act_en[c] <= sh_en[c];
          act_dut[c] <= sh_dut[c];
        end
        if (state == EXEC && op == 3'd5) begin
          sh_off[c] <= data[OFFSET_WIDTH-1:0];
          sh_en[c] <= den;
        end
      end
      if (state == EXEC && op == 3'd0 && addr_ok) begin
        sh_off[idx] <= data[OFFSET_WIDTH-1:0];
        sh_en[idx] <= den;
      end
      if (state == EXEC && op == 3'd1 && addr_ok) sh_dut[idx] <= data[DUTY_WIDTH-1:0];
    end
  for (genvar i = 0; i < CHANNELS; i++) begin : g_out
    assign offsets[i*OFFSET_WIDTH +: OFFSET_WIDTH] = act_off[i];
    assign enables[i] = act_en[i];
    assign duties[i*DUTY_WIDTH +: DUTY_WIDTH] = act_dut[i];
  end
endmodule
